// File: rtl/pipeline_stall_controller.sv
// Stall/flush controller for a 5-stage pipeline with a waiting data-memory port.
// Define STALL_PERF_CNT_EN to build the saturating stall-cycle counter behind StallCnt_o.
module pipeline_stall_controller #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             LoadUse_i,
   input  logic             Flush_i,
   input  logic             MemReq_i,
   input  logic             MemAck_i,
   output logic             PC_En_o,
   output logic             IF_ID_En_o,
   output logic             IF_ID_Flush_o,
   output logic             ID_EX_En_o,
   output logic             ID_EX_Bubble_o,
   output logic             EX_MEM_En_o,
   output logic             MEM_WB_En_o,
   output logic             MEM_WB_Bubble_o,
   output logic [1:0]       State_o,
   output logic             Err_o,
   output logic [CNT_W-1:0] StallCnt_o
);

   typedef enum logic [1:0] {RUN = 2'b00, MEMW = 2'b01} state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       err_q, err_d;
   logic       hz_en;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         wcnt_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      wcnt_d          = wcnt_q;
      err_d           = err_q;
      hz_en           = 1'b0;
      PC_En_o         = 1'b1;
      IF_ID_En_o      = 1'b1;
      IF_ID_Flush_o   = 1'b0;
      ID_EX_En_o      = 1'b1;
      ID_EX_Bubble_o  = 1'b0;
      EX_MEM_En_o     = 1'b1;
      MEM_WB_En_o     = 1'b1;
      MEM_WB_Bubble_o = 1'b0;

      case (state_q)
         RUN: begin
            if (MemReq_i && !MemAck_i) begin
               PC_En_o         = 1'b0;
               IF_ID_En_o      = 1'b0;
               ID_EX_En_o      = 1'b0;
               EX_MEM_En_o     = 1'b0;
               MEM_WB_En_o     = 1'b0;
               MEM_WB_Bubble_o = 1'b1;
               state_d         = MEMW;
               wcnt_d          = 8'd1;
            end else begin
               hz_en = 1'b1;
            end
         end
         MEMW: begin
            // Ack beats timeout when both land in the same cycle.
            if (MemAck_i) begin
               state_d = RUN;
               wcnt_d  = 8'd0;
               hz_en   = 1'b1;
            end else if (wcnt_q == TIMEOUT_C) begin
               err_d           = 1'b1;
               MEM_WB_Bubble_o = 1'b1;
               state_d         = RUN;
               wcnt_d          = 8'd0;
            end else begin
               PC_En_o         = 1'b0;
               IF_ID_En_o      = 1'b0;
               ID_EX_En_o      = 1'b0;
               EX_MEM_En_o     = 1'b0;
               MEM_WB_En_o     = 1'b0;
               MEM_WB_Bubble_o = 1'b1;
               wcnt_d          = wcnt_q + 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 8'd0;
         end
      endcase

      // Load-use wins over flush; the branch is re-evaluated once the stall clears.
      if (hz_en) begin
         if (LoadUse_i) begin
            PC_En_o        = 1'b0;
            IF_ID_En_o     = 1'b0;
            ID_EX_Bubble_o = 1'b1;
         end else if (Flush_i) begin
            IF_ID_Flush_o = 1'b1;
         end
      end

      if (rst_i) begin
         PC_En_o         = 1'b0;
         IF_ID_En_o      = 1'b0;
         ID_EX_En_o      = 1'b0;
         EX_MEM_En_o     = 1'b0;
         MEM_WB_En_o     = 1'b0;
         IF_ID_Flush_o   = 1'b1;
         ID_EX_Bubble_o  = 1'b1;
         MEM_WB_Bubble_o = 1'b1;
      end
   end

   assign State_o = state_q;
   assign Err_o   = err_q;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (!PC_En_o && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign StallCnt_o = cnt_q;
`else
   assign StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller (TIMEOUT=4); follows STALL_PERF_CNT_EN.
module tb_pipeline_stall_controller;

   localparam int CNT_W = 16;

   // Control vector order: PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Bubble, EX_MEM_En, MEM_WB_En, MEM_WB_Bubble
   localparam logic [7:0] C_RUN = 8'b1101_0110;
   localparam logic [7:0] C_MST = 8'b0000_0001;
   localparam logic [7:0] C_LU  = 8'b0001_1110;
   localparam logic [7:0] C_FL  = 8'b1111_0110;
   localparam logic [7:0] C_RST = 8'b0010_1001;
   localparam logic [7:0] C_TO  = 8'b1101_0111;

   typedef struct packed {
      logic [7:0]       ctl;
      logic [1:0]       st;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i, LoadUse_i, Flush_i, MemReq_i, MemAck_i;
   logic PC_En_o, IF_ID_En_o, IF_ID_Flush_o, ID_EX_En_o, ID_EX_Bubble_o;
   logic EX_MEM_En_o, MEM_WB_En_o, MEM_WB_Bubble_o, Err_o;
   logic [1:0] State_o;
   logic [CNT_W-1:0] StallCnt_o;

   exp_t sb_q[$];
   int checks = 0;
   int errors = 0;
   logic [CNT_W-1:0] exp_cnt;

   always #5 clk_i = ~clk_i;

   pipeline_stall_controller #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .LoadUse_i(LoadUse_i), .Flush_i(Flush_i),
      .MemReq_i(MemReq_i), .MemAck_i(MemAck_i), .PC_En_o(PC_En_o),
      .IF_ID_En_o(IF_ID_En_o), .IF_ID_Flush_o(IF_ID_Flush_o),
      .ID_EX_En_o(ID_EX_En_o), .ID_EX_Bubble_o(ID_EX_Bubble_o),
      .EX_MEM_En_o(EX_MEM_En_o), .MEM_WB_En_o(MEM_WB_En_o),
      .MEM_WB_Bubble_o(MEM_WB_Bubble_o), .State_o(State_o), .Err_o(Err_o),
      .StallCnt_o(StallCnt_o)
   );

   // One cycle: drive inputs, push expectation, compare mid-cycle, then advance the counter model.
   task automatic step(input string tag, input logic r, input logic lu, input logic fl,
                       input logic mr, input logic ma, input logic [7:0] ctl,
                       input logic [1:0] st, input logic err);
      exp_t e, got;
      rst_i = r; LoadUse_i = lu; Flush_i = fl; MemReq_i = mr; MemAck_i = ma;
      e.ctl = ctl; e.st = st; e.err = err;
`ifdef STALL_PERF_CNT_EN
      e.cnt = exp_cnt;
`else
      e.cnt = '0;
`endif
      sb_q.push_back(e);
      #3;
      e = sb_q.pop_front();
      got.ctl = {PC_En_o, IF_ID_En_o, IF_ID_Flush_o, ID_EX_En_o, ID_EX_Bubble_o,
                 EX_MEM_En_o, MEM_WB_En_o, MEM_WB_Bubble_o};
      got.st  = State_o;
      got.err = Err_o;
      got.cnt = StallCnt_o;
      checks++;
      assert ({got.ctl, got.st, got.err} === {e.ctl, e.st, e.err}) else begin
         errors++;
         $error("FAIL %s ctl/state/err: got %b/%b/%b expected %b/%b/%b",
                tag, got.ctl, got.st, got.err, e.ctl, e.st, e.err);
      end
      checks++;
      assert (got.cnt === e.cnt) else begin
         errors++;
         $error("FAIL %s StallCnt: got %0d expected %0d", tag, got.cnt, e.cnt);
      end
      if (r) exp_cnt = '0;
      else if (!ctl[7] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1; LoadUse_i = 1'b0; Flush_i = 1'b0; MemReq_i = 1'b0; MemAck_i = 1'b0;
      exp_cnt = '0;
      @(posedge clk_i);
      #1;
      step("reset",      1, 0, 0, 0, 0, C_RST, 2'b00, 0);
      step("idle",       0, 0, 0, 0, 0, C_RUN, 2'b00, 0);
      step("lu_fl",      0, 1, 1, 0, 0, C_LU,  2'b00, 0);
      step("flush",      0, 0, 1, 0, 0, C_FL,  2'b00, 0);
      step("ack_no_req", 0, 0, 0, 0, 1, C_RUN, 2'b00, 0);
      step("zero_wait",  0, 1, 0, 1, 1, C_LU,  2'b00, 0);
      // Three-cycle memory wait, ack arrives with a flush pending
      step("mw_enter",   0, 0, 0, 1, 0, C_MST, 2'b00, 0);
      step("mw_w1",      0, 1, 1, 1, 0, C_MST, 2'b01, 0);
      step("mw_w2",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("mw_ack",     0, 0, 1, 1, 1, C_FL,  2'b01, 0);
      step("mw_done",    0, 0, 0, 0, 0, C_RUN, 2'b00, 0);
      // Ack coincides with WCNT==TIMEOUT
      step("at_enter",   0, 0, 0, 1, 0, C_MST, 2'b00, 0);
      step("at_w1",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("at_w2",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("at_w3",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("at_ack",     0, 0, 0, 1, 1, C_RUN, 2'b01, 0);
      step("at_done",    0, 0, 0, 0, 0, C_RUN, 2'b00, 0);
      // Timeout without ack sets the sticky error
      step("to_enter",   0, 0, 0, 1, 0, C_MST, 2'b00, 0);
      step("to_w1",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("to_w2",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("to_w3",      0, 0, 0, 1, 0, C_MST, 2'b01, 0);
      step("to_abort",   0, 0, 0, 1, 0, C_TO,  2'b01, 0);
      step("to_err",     0, 0, 0, 0, 0, C_RUN, 2'b00, 1);
      step("err_sticky", 0, 1, 0, 0, 0, C_LU,  2'b00, 1);
      // Reset mid-wait clears state, error and counter
      step("rw_enter",   0, 0, 0, 1, 0, C_MST, 2'b00, 1);
      step("rw_w1",      0, 0, 0, 1, 0, C_MST, 2'b01, 1);
      step("rw_rst",     1, 0, 0, 1, 0, C_RST, 2'b01, 1);
      step("rw_after",   0, 0, 0, 0, 0, C_RUN, 2'b00, 0);
      step("rw_idle",    0, 0, 0, 0, 0, C_RUN, 2'b00, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
